// File: rtl/ex_mem_skid_pkg.sv
// Shared types for the EX/MEM boundary.
// Entry layout {wd, wreg, wdata} and zero constants.
package ex_mem_skid_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
  } ex_mem_entry_t;

endpackage

// File: rtl/skid_slot.sv
// One valid bit plus one payload register.
// Clear wins over load and zeroes the payload.
module skid_slot
  import ex_mem_skid_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  ex_mem_entry_t d,
  output logic          valid,
  output ex_mem_entry_t q
);

  // valid/payload register; clear beats load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM two-entry skid buffer, registered ready.
// Optional ID bypass ports under EX_MEM_FWD_EN.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
`ifdef EX_MEM_FWD_EN
  output logic              fwd_we_o,
  output logic [ADDR_W-1:0] fwd_wd_o,
  output logic [DATA_W-1:0] fwd_wdata_o,
`endif
  output logic [DATA_W-1:0] wdata_o
);

  ex_mem_entry_t in_e, main_q, skid_q, main_d;
  logic main_v, skid_v;
  logic main_ld, main_clr;
  logic skid_ld, skid_clr;
  logic in_x, out_x, skid_nxt;
  logic rdy_q;

  assign in_e  = '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};
  assign in_x  = ex_valid_i & rdy_q;
  assign out_x = main_v & mem_ready_i;

  assign main_d = skid_v ? skid_q : in_e;

  // slot control derived from the occupancy state
  always_comb begin
    main_ld  = 1'b0;
    main_clr = flush_i;
    skid_ld  = 1'b0;
    skid_clr = flush_i;
    if (!flush_i) begin
      unique case (1'b1)
        skid_v: begin
          if (out_x) begin
            main_ld  = 1'b1;
            skid_clr = 1'b1;
          end
        end
        (main_v & ~skid_v): begin
          if (in_x && out_x)  main_ld  = 1'b1;
          else if (in_x)      skid_ld  = 1'b1;
          else if (out_x)     main_clr = 1'b1;
        end
        default: begin
          if (in_x) main_ld = 1'b1;
        end
      endcase
    end
  end

  assign skid_nxt = skid_ld | (skid_v & ~skid_clr);

  // ready is a flop so MEM stalls never reach EX combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_q <= 1'b1;
    else      rdy_q <= ~skid_nxt;
  end

  skid_slot u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_ld),
    .clr   (main_clr),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  skid_slot u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_ld),
    .clr   (skid_clr),
    .d     (in_e),
    .valid (skid_v),
    .q     (skid_q)
  );

  assign ex_ready_o  = rdy_q;
  assign mem_valid_o = main_v;
  assign wd_o        = main_q.wd;
  assign wreg_o      = main_q.wreg;
  assign wdata_o     = main_q.wdata;

`ifdef EX_MEM_FWD_EN
  ex_mem_entry_t yng;
  assign yng         = skid_v ? skid_q : main_q;
  assign fwd_we_o    = (skid_v | main_v) & yng.wreg;
  assign fwd_wd_o    = yng.wd;
  assign fwd_wdata_o = yng.wdata;
`endif

endmodule
